gemm_acc_seq: RTL and testbench



---
 rtl/gemm_acc_seq.sv | 67 ++++++
 tb/tb_gemm_acc_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gemm_acc_seq.sv
// gemm_acc_seq: beat sequencer and accumulator register around one 16-lane systolic row
module gemm_acc_seq #(
  parameter int INP_WIDTH = 8,
  parameter int WGT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 8,
  parameter int IT_WIDTH = 16 * INP_WIDTH,
  parameter int WT_WIDTH = 16 * WGT_WIDTH,
  parameter int AT_WIDTH = 16 * ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 acc_init_en,
  input  logic [AT_WIDTH-1:0]  acc_init,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IT_WIDTH-1:0]  i_vec,
  input  logic [WT_WIDTH-1:0]  w_vec,
  output logic [IT_WIDTH-1:0]  row_i,
  output logic [WT_WIDTH-1:0]  row_w,
  output logic [AT_WIDTH-1:0]  row_a,
  input  logic [AT_WIDTH-1:0]  row_o,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AT_WIDTH-1:0]  out_acc,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [AT_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0] cnt;
  logic fire;
  assign fire = in_valid && in_ready;
  assign row_i = i_vec;
  assign row_w = w_vec;
  assign row_a = acc;
  assign out_acc = acc;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // next state: a zero-length job goes straight to DONE; the last accepted beat ends RUN
  always_comb
    state_nxt = state == IDLE ? (start ? (len == '0 ? DONE : RUN) : IDLE) :
                state == RUN  ? (fire && cnt == LEN_WIDTH'(1) ? DONE : RUN) :
                                (out_ready ? IDLE : DONE);
  // handshake outputs decoded from state only
  always_comb begin
    in_ready = state == RUN;
    out_valid = state == DONE;
    busy = state != IDLE;
  end
  // accumulator and beat counter: preload on start, capture the row output on each beat
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (state == IDLE && start) begin
      acc <= acc_init_en ? acc_init : '0;
      cnt <= len;
    end else if (fire) begin
      acc <= row_o;
      cnt <= cnt - LEN_WIDTH'(1);
    end
endmodule

// File: tb/tb_gemm_acc_seq.sv
// tb_gemm_acc_seq: directed jobs with a scoreboard checking each accepted result
module tb_gemm_acc_seq;
  logic clk = 0, rst = 1, start = 0, acc_init_en = 0, in_valid = 0, out_ready = 0;
  logic [7:0] len = 0;
  logic [511:0] acc_init = '0, row_a, row_o, out_acc;
  logic [127:0] i_vec = '0, w_vec = '0, row_i, row_w;
  logic in_ready, out_valid, busy;
  logic [511:0] exp_q[$];
  int total = 0, bad = 0, cyc;
  logic [511:0] v;

  gemm_acc_seq dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .acc_init_en(acc_init_en),
    .acc_init(acc_init), .in_valid(in_valid), .in_ready(in_ready), .i_vec(i_vec),
    .w_vec(w_vec), .row_i(row_i), .row_w(row_w), .row_a(row_a), .row_o(row_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_o = '0;
    for (int k = 0; k < 16; k++)
      row_o[32*k +: 32] = row_a[32*k +: 32] + 32'(row_i[8*k +: 8]) * 32'(row_w[8*k +: 8]);
  end

  function automatic logic [127:0] f8(input logic [7:0] x);
    for (int k = 0; k < 16; k++) f8[8*k +: 8] = x;
  endfunction

  function automatic logic [511:0] f32(input logic [31:0] x);
    for (int k = 0; k < 16; k++) f32[32*k +: 32] = x;
  endfunction

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] n, input logic en, input logic [511:0] init);
    start = 1; len = n; acc_init_en = en; acc_init = init;
    tick();
    start = 0; acc_init_en = 0;
  endtask

  task automatic wait_done(output int c);
    c = 1;
    while (!out_valid && c < 40) begin
      tick();
      c++;
    end
  endtask

  task automatic drain();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  always @(negedge clk)
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", out_acc, 'x);
      else chk("result", out_acc, exp_q.pop_front());
    end

  initial begin
    tick(); tick();
    rst = 0;
    chk("reset_ctl", {in_ready, out_valid, busy}, 0);
    chk("reset_acc", out_acc, 0);
    chk("reset_row_a", row_a, 0);

    i_vec = f8(2); w_vec = f8(3); in_valid = 1;
    exp_q.push_back(f32(18));
    go(3, 0, '0);
    chk("start_in_ready", in_ready, 1);
    wait_done(cyc);
    chk("lat_3beat", cyc, 4);
    in_valid = 0;
    drain();
    chk("busy_after", busy, 0);

    for (int k = 0; k < 16; k++) v[32*k +: 32] = 32'(k);
    i_vec = f8(1); w_vec = f8(1); in_valid = 1;
    for (int k = 0; k < 16; k++) exp_q.push_back(0);
    exp_q.pop_back();
    exp_q.delete();
    begin
      logic [511:0] e;
      for (int k = 0; k < 16; k++) e[32*k +: 32] = 32'(k + 1);
      exp_q.push_back(e);
    end
    go(1, 1, v);
    wait_done(cyc);
    chk("lat_bias", cyc, 2);
    in_valid = 0;
    drain();

    i_vec = f8(1); w_vec = f8(5);
    exp_q.push_back(f32(20));
    go(4, 0, '0);
    begin
      logic [5:0] pat;
      pat = 6'b110101;
      for (int p = 0; p < 6; p++) begin
        in_valid = pat[p];
        tick();
      end
    end
    in_valid = 0;
    chk("bp_done", out_valid, 1);
    for (int h = 0; h < 5; h++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_acc", out_acc, f32(20));
      tick();
    end
    drain();
    chk("bp_idle", {busy, out_valid}, 0);

    exp_q.push_back('0);
    go(0, 0, '0);
    chk("len0_valid", out_valid, 1);
    chk("len0_in_ready", in_ready, 0);
    chk("len0_acc", out_acc, 0);
    drain();

    i_vec = f8(1); w_vec = f8(2); in_valid = 1;
    exp_q.push_back(f32(6));
    go(3, 0, '0);
    start = 1; len = 7; acc_init_en = 1; acc_init = f32(100);
    tick();
    start = 0; acc_init_en = 0;
    cyc = 2;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("ign_start_lat", cyc, 4);
    in_valid = 0;
    drain();

    i_vec = f8(1); w_vec = f8(1); in_valid = 1;
    go(5, 0, '0);
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_ctl", {in_ready, out_valid, busy}, 0);
    chk("mid_rst_acc", out_acc, 0);
    chk("mid_rst_row_a", row_a, 0);
    i_vec = f8(3); w_vec = f8(3);
    exp_q.push_back(f32(9));
    go(1, 0, '0);
    wait_done(cyc);
    chk("lat_after_rst", cyc, 2);
    in_valid = 0;
    drain();

    for (int k = 0; k < 16; k++) v[32*k +: 32] = (k == 5) ? 32'hFFFF_FFFF : 32'(k);
    begin
      logic [511:0] e;
      for (int k = 0; k < 16; k++) e[32*k +: 32] = (k == 5) ? 32'd0 : 32'(k + 1);
      exp_q.push_back(e);
    end
    i_vec = f8(1); w_vec = f8(1); in_valid = 1;
    go(1, 1, v);
    wait_done(cyc);
    in_valid = 0;
    drain();

    tick(); tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
